// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer holding an instruction word and its PC while ID is frozen.
module fetch_hold_buf (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_word,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_word,
  output logic [31:0] o_pc
);
  logic        r_valid;
  logic [31:0] r_word;
  logic [31:0] r_pc;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding IMem request, word presented to ID one cycle after ack.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirects raise a sticky Fetch_Fault instead of being truncated.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  Cache_ready,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  input  logic [31:0] Alt_PC,
  input  logic        Request_Alt_PC,
  input  logic        WANT_FREEZE,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        Fetch_Fault
);
  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic        r_started;
  logic        r_squash;
  logic [31:0] r_pc;
  logic [31:0] r_sq_addr;
  logic [31:0] r_instr;
  logic [31:0] r_ipc;
  logic [31:0] r_ipc4;
  logic        w_cache_ok;
  logic        w_xfer;
  logic        w_take;
  logic        w_misalign;
  logic        w_hb_load;
  logic        w_hb_clear;
  logic        w_hb_vld;
  logic [31:0] w_alt;
  logic [31:0] w_hb_word;
  logic [31:0] w_hb_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  assign w_alt       = Alt_PC;
  assign w_misalign  = Request_Alt_PC && (Alt_PC[1:0] != 2'b00);
  assign Fetch_Fault = r_fault;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          r_fault <= 1'b0;
    else if (w_misalign) r_fault <= 1'b1;
  end
`else
  assign w_alt       = Alt_PC & 32'hFFFF_FFFC;
  assign w_misalign  = 1'b0;
  assign Fetch_Fault = 1'b0;
`endif

  assign w_cache_ok = |Cache_ready;
  assign w_xfer     = IMem_Req & IMem_Ack;
  // A word is kept only if it was not requested before a redirect.
  assign w_take     = w_xfer & ~r_squash & ~Request_Alt_PC;
  assign w_hb_load  = (r_state == ST_ISSUE) & w_take & WANT_FREEZE;
  assign w_hb_clear = Request_Alt_PC | ~w_cache_ok | ((r_state == ST_HOLD) & ~WANT_FREEZE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_ISSUE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ISSUE: begin
        if (w_misalign)                 w_state_nxt = ST_FAULT;
        else if (w_take && WANT_FREEZE) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_misalign)                                          w_state_nxt = ST_FAULT;
        else if (Request_Alt_PC || !w_cache_ok || !WANT_FREEZE) w_state_nxt = ST_ISSUE;
      end
      default: w_state_nxt = ST_FAULT;
    endcase
  end

  // While squashing, the address stays on the abandoned request until its ack arrives.
  always_comb begin
    IMem_Req  = r_started && (r_state == ST_ISSUE) && w_cache_ok;
    IMem_Addr = r_squash ? r_sq_addr : r_pc;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_started <= 1'b0;
      r_pc      <= RESET_PC;
      r_squash  <= 1'b0;
      r_sq_addr <= '0;
      r_instr   <= NOP_WORD;
      r_ipc     <= '0;
      r_ipc4    <= '0;
    end else begin
      r_started <= 1'b1;

      if (Request_Alt_PC) r_pc <= w_alt;
      else if (w_take)    r_pc <= pc_plus4(r_pc);

      if (!w_cache_ok || w_misalign) begin
        r_squash <= 1'b0;
      end else if (Request_Alt_PC && IMem_Req && !IMem_Ack) begin
        r_squash <= 1'b1;
        if (!r_squash) r_sq_addr <= r_pc;
      end else if (w_xfer) begin
        r_squash <= 1'b0;
      end

      if ((r_state == ST_FAULT) || w_misalign || !w_cache_ok) begin
        r_instr <= NOP_WORD;
      end else if (!WANT_FREEZE) begin
        if ((r_state == ST_HOLD) && w_hb_vld && !Request_Alt_PC) begin
          r_instr <= w_hb_word;
          r_ipc   <= w_hb_pc;
          r_ipc4  <= pc_plus4(w_hb_pc);
        end else if (w_take) begin
          r_instr <= IMem_Data;
          r_ipc   <= r_pc;
          r_ipc4  <= pc_plus4(r_pc);
        end else begin
          r_instr <= NOP_WORD;
        end
      end
    end
  end

  fetch_hold_buf u_hold_buf (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_load  (w_hb_load),
    .i_clear (w_hb_clear),
    .i_word  (IMem_Data),
    .i_pc    (r_pc),
    .o_valid (w_hb_vld),
    .o_word  (w_hb_word),
    .o_pc    (w_hb_pc)
  );

  assign Instr1_OUT         = r_instr;
  assign Instr_PC_OUT       = r_ipc;
  assign Instr_PC_Plus4_OUT = r_ipc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns address ^ 0x5A5A0000 as the instruction word.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  Cache_ready;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  logic [31:0] Alt_PC;
  logic        Request_Alt_PC;
  logic        WANT_FREEZE;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Fetch_Fault;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = FETCH_NOP_WORD;

  always #5 CLK = ~CLK;

  assign IMem_Data = IMem_Addr ^ 32'h5A5A_0000;

  fetch_unit dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Cache_ready        (Cache_ready),
    .IMem_Req           (IMem_Req),
    .IMem_Addr          (IMem_Addr),
    .IMem_Ack           (IMem_Ack),
    .IMem_Data          (IMem_Data),
    .Alt_PC             (Alt_PC),
    .Request_Alt_PC     (Request_Alt_PC),
    .WANT_FREEZE        (WANT_FREEZE),
    .Instr1_OUT         (Instr1_OUT),
    .Instr_PC_OUT       (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
    .Fetch_Fault        (Fetch_Fault)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [31:0] ei, input logic [31:0] epc, input logic [31:0] epc4);
    chk({tag, "_instr"}, Instr1_OUT, ei);
    chk({tag, "_pc"}, Instr_PC_OUT, epc);
    chk({tag, "_pc4"}, Instr_PC_Plus4_OUT, epc4);
  endtask

  initial begin
    RESET = 1'b0; Cache_ready = 2'b01; IMem_Ack = 1'b0;
    Alt_PC = '0; Request_Alt_PC = 1'b0; WANT_FREEZE = 1'b0;
    repeat (2) tick();
    chk("rst_req", IMem_Req, 0);
    chk("rst_fault", Fetch_Fault, 0);
    outs("rst", NOP, 32'h0, 32'h0);

    // Zero-wait streaming after release
    RESET = 1'b1; IMem_Ack = 1'b1;
    tick();
    chk("first_req", IMem_Req, 1);
    chk("first_addr", IMem_Addr, 32'h0040_0000);
    tick(); outs("seq0", dat(32'h0040_0000), 32'h0040_0000, 32'h0040_0004);
    tick(); outs("seq1", dat(32'h0040_0004), 32'h0040_0004, 32'h0040_0008);
    tick(); outs("seq2", dat(32'h0040_0008), 32'h0040_0008, 32'h0040_000C);

    // Ack delayed three cycles
    IMem_Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", IMem_Addr, 32'h0040_000C);
      outs("wait_nop", NOP, 32'h0040_0008, 32'h0040_000C);
    end
    IMem_Ack = 1'b1;
    tick(); outs("late_word", dat(32'h0040_000C), 32'h0040_000C, 32'h0040_0010);

    // Freeze for four edges with an ack landing during it
    IMem_Ack = 1'b0; WANT_FREEZE = 1'b1;
    tick(); outs("frz0", dat(32'h0040_000C), 32'h0040_000C, 32'h0040_0010);
    IMem_Ack = 1'b1;
    tick(); outs("frz1", dat(32'h0040_000C), 32'h0040_000C, 32'h0040_0010);
    chk("frz_hold_req", IMem_Req, 0);
    IMem_Ack = 1'b0;
    tick(); outs("frz2", dat(32'h0040_000C), 32'h0040_000C, 32'h0040_0010);
    tick(); outs("frz3", dat(32'h0040_000C), 32'h0040_000C, 32'h0040_0010);
    WANT_FREEZE = 1'b0;
    tick(); outs("unfrz", dat(32'h0040_0010), 32'h0040_0010, 32'h0040_0014);
    chk("unfrz_addr", IMem_Addr, 32'h0040_0014);
    IMem_Ack = 1'b1;
    tick(); outs("after_frz", dat(32'h0040_0014), 32'h0040_0014, 32'h0040_0018);

    // Redirect while a request is outstanding
    IMem_Ack = 1'b0; Alt_PC = 32'h0040_0100; Request_Alt_PC = 1'b1;
    tick();
    chk("sq_addr_stable", IMem_Addr, 32'h0040_0018);
    outs("sq_nop", NOP, 32'h0040_0014, 32'h0040_0018);
    Request_Alt_PC = 1'b0; IMem_Ack = 1'b1;
    tick();
    outs("sq_drop", NOP, 32'h0040_0014, 32'h0040_0018);
    chk("redir_addr", IMem_Addr, 32'h0040_0100);
    tick(); outs("redir_word", dat(32'h0040_0100), 32'h0040_0100, 32'h0040_0104);

    // Repeated identical redirect
    IMem_Ack = 1'b0; Alt_PC = 32'h0040_0200; Request_Alt_PC = 1'b1;
    tick(); tick();
    chk("idem_addr", IMem_Addr, 32'h0040_0104);
    Request_Alt_PC = 1'b0; IMem_Ack = 1'b1;
    tick(); chk("idem_next", IMem_Addr, 32'h0040_0200);
    tick(); outs("idem_word", dat(32'h0040_0200), 32'h0040_0200, 32'h0040_0204);

    // Redirect coinciding with a transfer
    Alt_PC = 32'h0040_0300; Request_Alt_PC = 1'b1;
    tick();
    outs("coin_drop", NOP, 32'h0040_0200, 32'h0040_0204);
    chk("coin_addr", IMem_Addr, 32'h0040_0300);
    Request_Alt_PC = 1'b0;
    tick(); outs("coin_word", dat(32'h0040_0300), 32'h0040_0300, 32'h0040_0304);

    // Misaligned redirect
    Alt_PC = 32'h0040_0102; Request_Alt_PC = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    chk("fault_set", Fetch_Fault, 1);
    chk("fault_req", IMem_Req, 0);
    Request_Alt_PC = 1'b0;
    repeat (3) tick();
    chk("fault_sticky", Fetch_Fault, 1);
    outs("fault_nop", NOP, 32'h0040_0300, 32'h0040_0304);
    RESET = 1'b0;
    tick(); chk("fault_rst", Fetch_Fault, 0);
    RESET = 1'b1;
    tick();
`else
    tick();
    chk("mis_addr", IMem_Addr, 32'h0040_0100);
    chk("mis_fault", Fetch_Fault, 0);
    Request_Alt_PC = 1'b0;
    tick(); outs("mis_word", dat(32'h0040_0100), 32'h0040_0100, 32'h0040_0104);
`endif

    // PC wrap at the top of the address space
    IMem_Ack = 1'b1; Alt_PC = 32'hFFFF_FFFC; Request_Alt_PC = 1'b1;
    tick(); chk("wrap_addr", IMem_Addr, 32'hFFFF_FFFC);
    Request_Alt_PC = 1'b0;
    tick();
    outs("wrap_word", dat(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0000_0000);
    chk("wrap_next", IMem_Addr, 32'h0000_0000);
    tick(); outs("wrap_zero", dat(32'h0000_0000), 32'h0000_0000, 32'h0000_0004);

    // Reset in the middle of a wait; late ack must not be captured
    IMem_Ack = 1'b0;
    tick(); chk("mid_addr", IMem_Addr, 32'h0000_0004);
    RESET = 1'b0;
    #1;
    chk("mid_rst_req", IMem_Req, 0);
    outs("mid_rst", NOP, 32'h0, 32'h0);
    IMem_Ack = 1'b1;
    tick();
    chk("mid_rst_req2", IMem_Req, 0);
    outs("mid_rst_late", NOP, 32'h0, 32'h0);
    RESET = 1'b1;
    tick();
    chk("restart_addr", IMem_Addr, 32'h0040_0000);
    chk("restart_instr", Instr1_OUT, NOP);
    tick(); outs("restart_word", dat(32'h0040_0000), 32'h0040_0000, 32'h0040_0004);

    // Cache not ready
    Cache_ready = 2'b00;
    tick();
    chk("cnr_req", IMem_Req, 0);
    chk("cnr_addr", IMem_Addr, 32'h0040_0004);
    outs("cnr", NOP, 32'h0040_0000, 32'h0040_0004);
    Cache_ready = 2'b10;
    tick(); outs("cr_word", dat(32'h0040_0004), 32'h0040_0004, 32'h0040_0008);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000: bubble instruction presented to ID.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: CLK in 1 (all state on rising edge); RESET in 1 (asserted low, asynchronous).
REQ-004 SHALL have port Cache_ready  in  2  cache subsystem ready; value 0 = not ready.
REQ-005 SHALL have port IMem_Req  out  1  instruction-memory request valid.
REQ-006 SHALL have port IMem_Addr  out  32  word-aligned fetch address.
REQ-007 SHALL have port IMem_Ack  in  1  response valid; a transfer occurs on any edge with IMem_Req=IMem_Ack=1.
REQ-008 SHALL have port IMem_Data  in  32  instruction word, valid with IMem_Ack.
REQ-009 SHALL have port Alt_PC  in  32  redirect target from ID.
REQ-010 SHALL have port Request_Alt_PC  in  1  redirect strobe from ID.
REQ-011 SHALL have port WANT_FREEZE  in  1  ID stall request.
REQ-012 SHALL have port Instr1_OUT  out  32  instruction to ID.
REQ-013 SHALL have port Instr_PC_OUT  out  32  PC of Instr1_OUT.
REQ-014 SHALL have port Instr_PC_Plus4_OUT  out  32  Instr_PC_OUT+4.
REQ-015 SHALL have port Fetch_Fault  out  1  sticky misaligned-redirect flag.

Function
REQ-016 SHALL run an FSM with states ISSUE (request pending), HOLD (word buffered during freeze), FAULT.
REQ-017 SHALL keep at most one request outstanding; IMem_Addr SHALL stay stable while IMem_Req=1 and IMem_Ack=0.
REQ-018 SHALL assert IMem_Req in ISSUE whenever Cache_ready!=0; IMem_Req SHALL be 0 in HOLD and FAULT.
REQ-019 On a transfer with no freeze, no redirect and no squash, SHALL register Instr1_OUT=IMem_Data, Instr_PC_OUT=PC, Instr_PC_Plus4_OUT=PC+4, and set PC=PC+4, giving one-cycle latency from ack.
REQ-020 On an edge with no transfer and WANT_FREEZE=0, SHALL register Instr1_OUT=NOP_WORD and leave Instr_PC_OUT unchanged.
REQ-021 While WANT_FREEZE=1, SHALL hold Instr1_OUT, Instr_PC_OUT and Instr_PC_Plus4_OUT unchanged; a transfer completing then SHALL be captured in the hold buffer, moving the FSM to HOLD.
REQ-022 In HOLD, on the first edge with WANT_FREEZE=0, SHALL present the buffered word to ID and return to ISSUE.
REQ-023 On Request_Alt_PC=1, SHALL load PC=Alt_PC, discard the hold buffer, and, if a request is outstanding, set a squash flag; this SHALL apply even during freeze.
REQ-024 A transfer with the squash flag set SHALL be discarded (not presented), clear the flag, and issue Alt_PC on the next cycle.
REQ-025 If Request_Alt_PC and a transfer coincide, SHALL discard the transfer and issue Alt_PC next cycle.
REQ-026 A repeated Request_Alt_PC with the same Alt_PC SHALL be idempotent.
REQ-027 SHALL wrap PC+4 modulo 2^32: 32'hFFFFFFFC goes to 32'h00000000.
REQ-028 While Cache_ready==0, SHALL hold PC, drive Instr1_OUT=NOP_WORD, clear the hold buffer, and squash any outstanding request.

Reset
REQ-029 While RESET=0, SHALL set PC=RESET_PC, Instr1_OUT=NOP_WORD, Instr_PC_OUT=0, Instr_PC_Plus4_OUT=0, IMem_Req=0, Fetch_Fault=0, squash=0, and FSM=ISSUE.
REQ-030 On reset assertion mid-transfer, SHALL abandon the outstanding request with no late-data capture, and issue RESET_PC after release.

Configuration
REQ-031 With FETCH_ALIGN_CHECK_EN defined, a redirect with Alt_PC[1:0]!=0 SHALL set Fetch_Fault=1, enter FAULT, and present NOP_WORD until reset.
REQ-032 Without FETCH_ALIGN_CHECK_EN, SHALL force Alt_PC[1:0] to 2'b00; Fetch_Fault SHALL be tied to 0 and FAULT SHALL be unreachable.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state typedef, the NOP_WORD constant, and the default RESET_PC.
REQ-034 The one-entry hold buffer SHALL be a sub-module fetch_hold_buf (word+PC, load/clear/valid).

Verification
REQ-035 Zero-wait memory, no stalls: after release, Instr_PC_OUT SHALL read 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
REQ-036 Ack delayed 3 cycles: IMem_Addr SHALL stay stable for 3 cycles, and 3 NOP_WORDs SHALL be presented before the word.
REQ-037 WANT_FREEZE high 4 cycles with an ack during it: outputs SHALL be frozen, then the buffered word at PC+4 SHALL be presented on the first unfrozen edge with none lost.
REQ-038 Request_Alt_PC=1 with Alt_PC=0x00400100 while a request is outstanding: the late data SHALL be dropped and the next IMem_Addr SHALL be 0x00400100.
REQ-039 Alt_PC=0x00400102 with the macro defined: Fetch_Fault SHALL be 1 and NOPs SHALL persist until reset; without the macro, fetch SHALL proceed at 0x00400100.
REQ-040 PC at 0xFFFFFFFC: the next fetch SHALL be at 0x00000000; a mid-wait reset SHALL restart at RESET_PC.
